// File: rtl/tt_capture_pkg.sv
// Shared types and helpers for the truth-table capture block: FSM state
// encoding and the table-width helper.
package tt_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } tt_state_e;

  function automatic int TT_W(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/truth_table_capture_settle_timer.sv
// settle_timer: counts cycles spent holding one stimulus vector and flags the
// last settle cycle (count == SETTLE-1). Clear has priority over enable.
module settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam int            CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments only; all next-state
  // math lives in always_comb so the flop process stays a plain capture.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign hit_o = (cnt_q == LAST);

endmodule

// File: rtl/truth_table_capture.sv
// Sweeps all 2^N_IN input vectors of a 1-output DUT and captures its truth table.
// Optional golden compare enabled by defining TT_CAPTURE_COMPARE_EN.
module truth_table_capture
  import tt_capture_pkg::tt_state_e, tt_capture_pkg::TT_W,
         tt_capture_pkg::IDLE, tt_capture_pkg::SAMPLE, tt_capture_pkg::DONE;
#(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    resp,
`ifdef TT_CAPTURE_COMPARE_EN
  input  logic [TT_W(N_IN)-1:0]   exp_table,
  output logic [TT_W(N_IN)-1:0]   mismatch,
  output logic                    match,
`endif
  output logic [N_IN-1:0]         stim,
  output logic                    busy,
  output logic                    done,
  output logic                    valid,
  output logic [TT_W(N_IN)-1:0]   table_out
);

  localparam int              TW        = TT_W(N_IN);
  localparam logic [N_IN-1:0] STIM_LAST = '1;

  tt_state_e       state_q, state_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            valid_q, valid_d;
  logic [TW-1:0]   table_q, table_d;
  logic [TW-1:0]   shadow_q, shadow_d;
  logic            go;
  logic            tmr_hit;

  assign go = (state_q == IDLE) && start && !abort;

  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (state_q != tt_capture_pkg::SETTLE),
    .en_i  ((state_q == tt_capture_pkg::SETTLE) && !tmr_hit),
    .hit_o (tmr_hit)
  );

  // NOTE: every variable gets its hold value first so no path leaves one
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d  = state_q;
    stim_d   = stim_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    valid_d  = valid_q;
    table_d  = table_q;
    shadow_d = shadow_q;
    if (abort) begin
      // Abort wins over every transition; the last good table is kept.
      state_d = IDLE;
      stim_d  = '0;
      busy_d  = 1'b0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d  = tt_capture_pkg::SETTLE;
          stim_d   = '0;
          busy_d   = 1'b1;
          valid_d  = 1'b0;
          shadow_d = '0;
        end
        tt_capture_pkg::SETTLE: if (tmr_hit) state_d = SAMPLE;
        SAMPLE: begin
          shadow_d[stim_q] = resp;
          if (stim_q == STIM_LAST) begin
            state_d = DONE;
          end else begin
            stim_d  = stim_q + 1'b1;
            state_d = tt_capture_pkg::SETTLE;
          end
        end
        DONE: begin
          table_d = shadow_q;
          done_d  = 1'b1;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: the shadow table is a plain register, not a RAM, so it is reset
  // along with the rest of the state and a fresh sweep starts from zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      stim_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      table_q  <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      stim_q   <= stim_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      table_q  <= table_d;
      shadow_q <= shadow_d;
    end
  end

`ifdef TT_CAPTURE_COMPARE_EN
  logic [TW-1:0] mismatch_q, mismatch_d;
  logic          match_q, match_d;

  always_comb begin
    mismatch_d = mismatch_q;
    match_d    = match_q;
    if (abort || go) begin
      mismatch_d = '0;
      match_d    = 1'b0;
    end else if (state_q == DONE) begin
      mismatch_d = shadow_q ^ exp_table;
      match_d    = ((shadow_q ^ exp_table) == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mismatch_q <= '0;
      match_q    <= 1'b0;
    end else begin
      mismatch_q <= mismatch_d;
      match_q    <= match_d;
    end
  end

  assign mismatch = mismatch_q;
  assign match    = match_q;
`endif

  assign stim      = stim_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign valid     = valid_q;
  assign table_out = table_q;

endmodule

// File: tb/tb_truth_table_capture.sv
// Randomized scoreboard bench for truth_table_capture: the bench's DUT function
// is a table word f, and every completed sweep must return exactly f.
module tb_truth_table_capture;
  import tt_capture_pkg::*;

  localparam int N   = 4;
  localparam int ST  = 2;
  localparam int TW  = TT_W(N);
  localparam int LAT = TW * (ST + 1) + 1;

  typedef struct {
    logic [TW-1:0] tbl;
    logic [TW-1:0] exp;
    int unsigned   e0;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          resp;
  logic [N-1:0]  stim;
  logic          busy, done, valid;
  logic [TW-1:0] table_out;
  logic [TW-1:0] f_q = '0;
  logic [TW-1:0] exp_table_r = '0;
`ifdef TT_CAPTURE_COMPARE_EN
  logic [TW-1:0] mismatch;
  logic          match;
`endif

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int unsigned last_e0 = 0;
  logic [TW-1:0] last_table = '0;
  exp_t        exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural DUT: output for input vector k is bit k of f.
  assign resp = f_q[stim];

  truth_table_capture #(.N_IN(N), .SETTLE(ST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .resp      (resp),
`ifdef TT_CAPTURE_COMPARE_EN
    .exp_table (exp_table_r),
    .mismatch  (mismatch),
    .match     (match),
`endif
    .stim      (stim),
    .busy      (busy),
    .done      (done),
    .valid     (valid),
    .table_out (table_out)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding sweep.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", done, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("table_out", table_out, e.tbl);
        check("valid_at_done", valid, 1'b1);
        check("busy_at_done", busy, 1'b0);
        check("done_latency", cyc - e.e0, LAT);
`ifdef TT_CAPTURE_COMPARE_EN
        check("mismatch", mismatch, e.tbl ^ e.exp);
        check("match", match, (e.tbl ^ e.exp) == '0);
`endif
      end
    end
  end

  task automatic at_cycle(input int unsigned c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic start_sweep(input logic [TW-1:0] fn, input bit push);
    exp_t e;
    @(posedge clk); #1;
    f_q = fn;
    exp_table_r = ($urandom_range(1, 0) == 1) ? fn ^ (TW'(1) << $urandom_range(TW - 1, 0)) : fn;
    start = 1'b1;
    last_e0 = cyc + 1;
    if (push) begin
      e.tbl = fn;
      e.exp = exp_table_r;
      e.e0  = last_e0;
      exp_q.push_back(e);
      last_table = fn;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_sweeps();
    for (int i = 0; i < 4 * LAT && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      check("sweep_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic check_cleared(input string p);
    check({p, "_stim"}, stim, '0);
    check({p, "_busy"}, busy, 1'b0);
    check({p, "_done"}, done, 1'b0);
    check({p, "_valid"}, valid, 1'b0);
    check({p, "_table"}, table_out, '0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    rst_n = 1'b1;

    // Directed function: f=1 only for inputs 8, 9, 13, 14.
    start_sweep(TW'(16'h6300), 1'b1);
    check("sweep_busy", busy, 1'b1);
    check("sweep_stim0", stim, '0);
    check("sweep_valid_low", valid, 1'b0);
    wait_sweeps();
    repeat (3) @(posedge clk);
    #1;
    check("valid_hold", valid, 1'b1);
    check("table_hold", table_out, last_table);
    check("idle_busy", busy, 1'b0);

    // Constant-0 then constant-1 DUT; valid must drop on the second start.
    start_sweep('0, 1'b1);
    wait_sweeps();
    start_sweep('1, 1'b1);
    check("valid_drop", valid, 1'b0);
    wait_sweeps();

    // Re-pulsed start mid-sweep is ignored.
    start_sweep(TW'({$urandom(), $urandom()}), 1'b1);
    at_cycle(last_e0 + 4); start = 1'b1; @(posedge clk); #1; start = 1'b0;
    at_cycle(last_e0 + 19); start = 1'b1; @(posedge clk); #1; start = 1'b0;
    wait_sweeps();
    repeat (LAT) @(posedge clk);

    // Abort at cycle 30 of a sweep.
    start_sweep(TW'({$urandom(), $urandom()}), 1'b0);
    at_cycle(last_e0 + 29);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_stim", stim, '0);
    check("abort_valid", valid, 1'b0);
    check("abort_table", table_out, last_table);
    repeat (LAT + 10) @(posedge clk);
    #1;
    check("abort_table_later", table_out, last_table);
    check("abort_idle", busy, 1'b0);

    // Abort and start together in IDLE: no sweep.
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", busy, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("abort_start_busy_later", busy, 1'b0);

    // Reset at cycle 25 of a sweep.
    start_sweep(TW'({$urandom(), $urandom()}), 1'b0);
    at_cycle(last_e0 + 24);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_cleared("midreset");
    rst_n = 1'b1;
    last_table = '0;

    // Random sweeps after reset.
    for (int i = 0; i < 4; i++) begin
      start_sweep(TW'({$urandom(), $urandom()}), 1'b1);
      wait_sweeps();
      check("rand_table_hold", table_out, last_table);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
